// File: rtl/ahb_lite_decode_mux.sv
// ahb_lite_decode_mux: single-master AHB-Lite address decoder and response mux with a default ERROR slave
module ahb_lite_decode_mux #(
  parameter int NUM_SLAVES = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] BASE = {32'hB000_0000, 32'h5000_0000, 32'h4000_0000, 32'h2000_0000},
  parameter logic [NUM_SLAVES*ADDR_W-1:0] MASK = {4{32'hF000_0000}},
  parameter int CNT_W = 16
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [ADDR_W-1:0]            m_HADDR,
  input  logic [1:0]                   m_HTRANS,
  input  logic                         m_HWRITE,
  input  logic [2:0]                   m_HSIZE,
  input  logic [2:0]                   m_HBURST,
  input  logic [3:0]                   m_HPROT,
  input  logic                         m_HMASTLOCK,
  input  logic [DATA_W-1:0]            m_HWDATA,
  output logic [DATA_W-1:0]            m_HRDATA,
  output logic                         m_HREADY,
  output logic [1:0]                   m_HRESP,
  output logic [NUM_SLAVES-1:0]        s_HSEL,
  output logic [ADDR_W-1:0]            s_HADDR,
  output logic [1:0]                   s_HTRANS,
  output logic                         s_HWRITE,
  output logic [2:0]                   s_HSIZE,
  output logic [2:0]                   s_HBURST,
  output logic [3:0]                   s_HPROT,
  output logic                         s_HMASTLOCK,
  output logic [DATA_W-1:0]            s_HWDATA,
  output logic                         s_HREADY,
  input  logic [NUM_SLAVES-1:0]        s_HREADYOUT,
  input  logic [2*NUM_SLAVES-1:0]      s_HRESP,
  input  logic [DATA_W*NUM_SLAVES-1:0] s_HRDATA,
  output logic [CNT_W-1:0]             err_cnt,
  output logic                         err_pulse
);
  localparam int IW = NUM_SLAVES > 1 ? $clog2(NUM_SLAVES) : 1;
  localparam logic [1:0] IDLE = 2'd0, ERR1 = 2'd1, ERR2 = 2'd2;
  logic [IW-1:0] dec_idx, dp_idx;
  logic dec_hit, dp_def, dp_act, act, def_err;
  logic [1:0] st, st_nxt;
  if (NUM_SLAVES < 1 || NUM_SLAVES > 16) begin : g_bad
    $error("ahb_lite_decode_mux: NUM_SLAVES must be 1..16");
  end
  always_comb begin
    s_HSEL = '0;
    dec_hit = 1'b0;
    dec_idx = '0;
    for (int i = 0; i < NUM_SLAVES; i++)
      if (!dec_hit && (m_HADDR & MASK[i*ADDR_W +: ADDR_W]) == BASE[i*ADDR_W +: ADDR_W]) begin
        s_HSEL[i] = 1'b1;
        dec_hit = 1'b1;
        dec_idx = IW'(i);
      end
  end
  assign act = m_HTRANS[1];
  assign st_nxt = st == ERR1 ? ERR2 : !m_HREADY ? st : (!dec_hit && act) ? ERR1 : IDLE;
  always_ff @(posedge CLK)
    if (RST) begin
      dp_def <= 1'b1;
      dp_idx <= '0;
      dp_act <= 1'b0;
      st <= IDLE;
      err_cnt <= '0;
    end else begin
      st <= st_nxt;
      if (m_HREADY) begin
        dp_def <= !dec_hit;
        dp_idx <= dec_idx;
        dp_act <= act;
      end
      if (st_nxt == ERR1 && !(&err_cnt)) err_cnt <= err_cnt + 1'b1;
    end
  assign def_err = dp_act && st != IDLE;
  assign err_pulse = dp_act && st == ERR1;
  assign m_HREADY = dp_def ? st != ERR1 : s_HREADYOUT[dp_idx];
  assign m_HRESP = dp_def ? {1'b0, def_err} : s_HRESP[2*int'(dp_idx) +: 2];
  assign m_HRDATA = dp_def ? '0 : s_HRDATA[int'(dp_idx)*DATA_W +: DATA_W];
  assign s_HADDR = m_HADDR;
  assign s_HTRANS = m_HTRANS;
  assign s_HWRITE = m_HWRITE;
  assign s_HSIZE = m_HSIZE;
  assign s_HBURST = m_HBURST;
  assign s_HPROT = m_HPROT;
  assign s_HMASTLOCK = m_HMASTLOCK;
  assign s_HWDATA = m_HWDATA;
  assign s_HREADY = m_HREADY;
endmodule

// File: tb/tb_ahb_lite_decode_mux.sv
// tb_ahb_lite_decode_mux: directed and randomized checks of the AHB-Lite decoder/mux
module tb_ahb_lite_decode_mux;
  logic CLK = 1'b0, RST = 1'b1;
  logic [31:0] m_HADDR = '0, m_HWDATA = '0, m_HRDATA;
  logic [1:0] m_HTRANS = '0, m_HRESP;
  logic m_HWRITE = 1'b0, m_HMASTLOCK = 1'b0, m_HREADY;
  logic [2:0] m_HSIZE = 3'd2, m_HBURST = 3'd0;
  logic [3:0] m_HPROT = 4'h3;
  logic [3:0] s_HSEL, s_HPROT, s_HREADYOUT = 4'hF;
  logic [31:0] s_HADDR, s_HWDATA;
  logic [1:0] s_HTRANS;
  logic s_HWRITE, s_HMASTLOCK, s_HREADY, err_pulse;
  logic [2:0] s_HSIZE, s_HBURST;
  logic [7:0] s_HRESP = '0;
  logic [127:0] s_HRDATA = '0;
  logic [15:0] err_cnt;
  logic [31:0] d2_haddr = '0, d2_hrdata, d2_saddr, d2_swdata;
  logic [1:0] d2_htrans = '0, d2_hresp, d2_strans;
  logic d2_hready, d2_swrite, d2_slock, d2_sready, d2_pulse;
  logic [3:0] d2_sel, d2_sprot, d2_rdy = 4'hF;
  logic [2:0] d2_ssize, d2_sburst;
  logic [7:0] d2_resp = '0;
  logic [127:0] d2_rdata = '0;
  logic [1:0] d2_cnt;
  int checks = 0, errors = 0;
  int owner, errph, cnt, dec;
  logic hr;
  logic [3:0] exp_sel;
  always #5 CLK = ~CLK;
  ahb_lite_decode_mux dut (
    .CLK(CLK), .RST(RST), .m_HADDR(m_HADDR), .m_HTRANS(m_HTRANS), .m_HWRITE(m_HWRITE),
    .m_HSIZE(m_HSIZE), .m_HBURST(m_HBURST), .m_HPROT(m_HPROT), .m_HMASTLOCK(m_HMASTLOCK),
    .m_HWDATA(m_HWDATA), .m_HRDATA(m_HRDATA), .m_HREADY(m_HREADY), .m_HRESP(m_HRESP),
    .s_HSEL(s_HSEL), .s_HADDR(s_HADDR), .s_HTRANS(s_HTRANS), .s_HWRITE(s_HWRITE),
    .s_HSIZE(s_HSIZE), .s_HBURST(s_HBURST), .s_HPROT(s_HPROT), .s_HMASTLOCK(s_HMASTLOCK),
    .s_HWDATA(s_HWDATA), .s_HREADY(s_HREADY), .s_HREADYOUT(s_HREADYOUT), .s_HRESP(s_HRESP),
    .s_HRDATA(s_HRDATA), .err_cnt(err_cnt), .err_pulse(err_pulse)
  );
  ahb_lite_decode_mux #(
    .BASE({32'hB000_0000, 32'h5000_0000, 32'h2000_0000, 32'h2000_0000}),
    .CNT_W(2)
  ) dut2 (
    .CLK(CLK), .RST(RST), .m_HADDR(d2_haddr), .m_HTRANS(d2_htrans), .m_HWRITE(m_HWRITE),
    .m_HSIZE(m_HSIZE), .m_HBURST(m_HBURST), .m_HPROT(m_HPROT), .m_HMASTLOCK(m_HMASTLOCK),
    .m_HWDATA(m_HWDATA), .m_HRDATA(d2_hrdata), .m_HREADY(d2_hready), .m_HRESP(d2_hresp),
    .s_HSEL(d2_sel), .s_HADDR(d2_saddr), .s_HTRANS(d2_strans), .s_HWRITE(d2_swrite),
    .s_HSIZE(d2_ssize), .s_HBURST(d2_sburst), .s_HPROT(d2_sprot), .s_HMASTLOCK(d2_slock),
    .s_HWDATA(d2_swdata), .s_HREADY(d2_sready), .s_HREADYOUT(d2_rdy), .s_HRESP(d2_resp),
    .s_HRDATA(d2_rdata), .err_cnt(d2_cnt), .err_pulse(d2_pulse)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic cyc;
    @(posedge CLK);
    #1;
  endtask
  task automatic sm;
    #2;
  endtask
  task automatic drv(input logic [31:0] a, input logic [1:0] t);
    m_HADDR = a;
    m_HTRANS = t;
  endtask
  function automatic int dec_of(input logic [31:0] a);
    case (a[31:28])
      4'h2: return 0;
      4'h4: return 1;
      4'h5: return 2;
      4'hB: return 3;
      default: return -1;
    endcase
  endfunction
  initial begin
    s_HRDATA = {32'hABCD_ABCD, 32'h9999_0002, 32'h5678_5678, 32'h1324_1324};
    cyc;
    cyc;
    sm;
    chk("rst_hready", m_HREADY, 1);
    chk("rst_hresp", m_HRESP, 0);
    chk("rst_hrdata", m_HRDATA, 0);
    chk("rst_cnt", err_cnt, 0);
    chk("rst_pulse", err_pulse, 0);
    RST = 1'b0;
    cyc;
    drv(32'h2000_0000, 2'd2);
    m_HWRITE = 1'b1;
    m_HWDATA = 32'hDEAD_BEEF;
    sm;
    chk("t1_sel", s_HSEL, 4'b0001);
    chk("t1_haddr", s_HADDR, 32'h2000_0000);
    chk("t1_hwrite", s_HWRITE, 1);
    chk("t1_hwdata", s_HWDATA, 32'hDEAD_BEEF);
    chk("t1_htrans", s_HTRANS, 2);
    chk("t1_hsize_prot", {s_HSIZE, s_HPROT}, {3'd2, 4'h3});
    cyc;
    drv(32'h0, 2'd0);
    m_HWRITE = 1'b0;
    sm;
    chk("t1_rdata", m_HRDATA, 32'h1324_1324);
    chk("t1_hready", m_HREADY, 1);
    chk("t1_sready", s_HREADY, 1);
    chk("t1_hresp", m_HRESP, 0);
    cyc;
    drv(32'h4000_0000, 2'd2);
    sm;
    chk("t2_sel1", s_HSEL, 4'b0010);
    cyc;
    drv(32'h5500_0000, 2'd2);
    s_HREADYOUT = 4'b1101;
    for (int i = 0; i < 3; i++) begin
      sm;
      chk("t2_wait_hready", m_HREADY, 0);
      chk("t2_wait_sel", s_HSEL, 4'b0100);
      cyc;
    end
    s_HREADYOUT = 4'hF;
    sm;
    chk("t2_hready", m_HREADY, 1);
    chk("t2_rdata", m_HRDATA, 32'h5678_5678);
    cyc;
    drv(32'h0, 2'd0);
    sm;
    chk("t2_rdata_s2", m_HRDATA, 32'h9999_0002);
    cyc;
    drv(32'hF000_0000, 2'd2);
    sm;
    chk("t3_sel", s_HSEL, 4'b0000);
    cyc;
    drv(32'h0, 2'd0);
    sm;
    chk("t3_err1_hready", m_HREADY, 0);
    chk("t3_err1_hresp", m_HRESP, 1);
    chk("t3_err1_pulse", err_pulse, 1);
    chk("t3_err1_cnt", err_cnt, 1);
    chk("t3_err1_rdata", m_HRDATA, 0);
    cyc;
    sm;
    chk("t3_err2_hready", m_HREADY, 1);
    chk("t3_err2_hresp", m_HRESP, 1);
    chk("t3_err2_pulse", err_pulse, 0);
    cyc;
    sm;
    chk("t3_idle_hresp", m_HRESP, 0);
    chk("t3_idle_cnt", err_cnt, 1);
    drv(32'hF000_0000, 2'd2);
    cyc;
    drv(32'hE000_0000, 2'd2);
    sm;
    chk("b2b_err1a_hready", m_HREADY, 0);
    chk("b2b_err1a_cnt", err_cnt, 2);
    cyc;
    sm;
    chk("b2b_err2a", {m_HREADY, m_HRESP, err_pulse}, {1'b1, 2'd1, 1'b0});
    cyc;
    drv(32'h0, 2'd0);
    sm;
    chk("b2b_err1b", {m_HREADY, m_HRESP, err_pulse}, {1'b0, 2'd1, 1'b1});
    chk("b2b_err1b_cnt", err_cnt, 3);
    cyc;
    cyc;
    sm;
    chk("b2b_idle", {m_HREADY, m_HRESP}, {1'b1, 2'd0});
    drv(32'hF000_0000, 2'd0);
    cyc;
    drv(32'hF000_0000, 2'd1);
    sm;
    chk("t4_idle", {m_HREADY, m_HRESP, err_pulse}, {1'b1, 2'd0, 1'b0});
    chk("t4_idle_cnt", err_cnt, 3);
    cyc;
    drv(32'h0, 2'd0);
    sm;
    chk("t4_busy", {m_HREADY, m_HRESP, err_pulse}, {1'b1, 2'd0, 1'b0});
    chk("t4_busy_cnt", err_cnt, 3);
    drv(32'hB000_0000, 2'd2);
    s_HRESP = 8'b01_00_00_00;
    sm;
    chk("t5_sel3", s_HSEL, 4'b1000);
    cyc;
    drv(32'h0, 2'd0);
    sm;
    chk("t5_rdata", m_HRDATA, 32'hABCD_ABCD);
    chk("t5_hresp", m_HRESP, 1);
    s_HRESP = '0;
    d2_haddr = 32'h2000_0000;
    d2_htrans = 2'd2;
    sm;
    chk("t5_overlap_sel", d2_sel, 4'b0001);
    d2_htrans = 2'd0;
    cyc;
    drv(32'hF000_0000, 2'd2);
    cyc;
    drv(32'h0, 2'd0);
    sm;
    chk("t6_err1_hready", m_HREADY, 0);
    RST = 1'b1;
    cyc;
    sm;
    chk("t6_rst_err", {m_HREADY, m_HRESP, err_pulse}, {1'b1, 2'd0, 1'b0});
    chk("t6_rst_err_cnt", err_cnt, 0);
    chk("t6_rst_err_rdata", m_HRDATA, 0);
    RST = 1'b0;
    drv(32'h4000_0000, 2'd2);
    s_HREADYOUT = 4'b1101;
    cyc;
    drv(32'h0, 2'd0);
    sm;
    chk("t6_wait_hready", m_HREADY, 0);
    RST = 1'b1;
    cyc;
    sm;
    chk("t6_rst_wait", {m_HREADY, m_HRESP}, {1'b1, 2'd0});
    chk("t6_rst_wait_rdata", m_HRDATA, 0);
    RST = 1'b0;
    s_HREADYOUT = 4'hF;
    d2_haddr = 32'hF000_0000;
    d2_htrans = 2'd2;
    repeat (5) cyc;
    sm;
    chk("sat_cnt3", d2_cnt, 3);
    repeat (3) cyc;
    d2_htrans = 2'd0;
    cyc;
    cyc;
    sm;
    chk("sat_cnt_hold", d2_cnt, 3);
    chk("sat_idle_hready", d2_hready, 1);
    RST = 1'b1;
    cyc;
    RST = 1'b0;
    owner = -1;
    errph = 0;
    cnt = 0;
    hr = 1'b1;
    for (int c = 0; c < 400; c++) begin
      if (hr) begin
        m_HADDR = $urandom_range(0, 1) ? {4'h2 + 4'($urandom_range(0, 9)), 28'($urandom)} : $urandom;
        m_HTRANS = 2'($urandom_range(0, 3));
      end
      for (int i = 0; i < 4; i++) s_HREADYOUT[i] = $urandom_range(0, 3) != 0;
      s_HRESP = 8'($urandom);
      s_HRDATA = {$urandom, $urandom, $urandom, $urandom};
      dec = dec_of(m_HADDR);
      exp_sel = dec < 0 ? 4'b0 : 4'b1 << dec;
      hr = owner >= 0 ? s_HREADYOUT[owner] : errph != 1;
      sm;
      chk("rnd_sel", s_HSEL, exp_sel);
      chk("rnd_hready", m_HREADY, hr);
      chk("rnd_hresp", m_HRESP, owner >= 0 ? s_HRESP[owner*2 +: 2] : (errph != 0 ? 2'd1 : 2'd0));
      chk("rnd_rdata", m_HRDATA, owner >= 0 ? s_HRDATA[owner*32 +: 32] : 32'h0);
      chk("rnd_pulse", err_pulse, errph == 1);
      chk("rnd_cnt", err_cnt, cnt);
      cyc;
      if (errph == 1) errph = 2;
      else if (hr) begin
        owner = dec;
        if (dec < 0 && m_HTRANS >= 2) begin
          errph = 1;
          cnt = cnt == 65535 ? cnt : cnt + 1;
        end else errph = 0;
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
